// File: rtl/weather_feature_extractor.sv
// Aggregates one window of raw weather samples into four 4-bit classifier features.
// Latency 1 cycle after the closing sample; result held under valid/ready, sticky overrun on drop.
module weather_feature_extractor #(
    parameter int SAMPLES_PER_DAY = 24,
    parameter int TEMP_LO         = -20,
    parameter int TEMP_SHIFT      = 2,
    parameter int PRECIP_SHIFT    = 3,
    parameter int WIND_SHIFT      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic signed [7:0] sample_temp,
    input  logic        [7:0] sample_precip,
    input  logic        [7:0] sample_wind,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic        [3:0] feat_temp_max,
    output logic        [3:0] feat_temp_min,
    output logic        [3:0] feat_precipitation,
    output logic        [3:0] feat_wind,
    output logic              overrun
);

    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic        [7:0] LAST_IDX   = 8'(SAMPLES_PER_DAY - 1);
    localparam logic signed [9:0] TEMP_LO_10 = 10'(TEMP_LO);

    state_t            state_q, state_d;
    logic        [7:0] cnt_q;
    logic signed [7:0] tmax_q, tmin_q, tmax_n, tmin_n;
    logic       [15:0] psum_q, psum_n;
    logic        [7:0] wpeak_q, wpeak_n;
    logic       [16:0] psum_wide;
    logic              close, load;

    function automatic logic [3:0] quant_temp(input logic signed [7:0] t);
        logic signed [9:0] d;
        logic signed [9:0] q;
        d = $signed({{2{t[7]}}, t}) - TEMP_LO_10;
        q = d >>> TEMP_SHIFT;
        if (d < 0)
            return 4'd0;
        else if (q > 10'sd15)
            return 4'd15;
        else
            return q[3:0];
    endfunction

    function automatic logic [3:0] quant_u16(input logic [15:0] v, input int sh);
        logic [15:0] q;
        q = v >> sh;
        return (q > 16'd15) ? 4'd15 : q[3:0];
    endfunction

    assign close = sample_valid && (cnt_q == LAST_IDX);
    // A closing window only reaches the output if the held result is gone by this edge.
    assign load  = close && (!feat_valid || feat_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        tmax_n    = tmax_q;
        tmin_n    = tmin_q;
        psum_n    = psum_q;
        wpeak_n   = wpeak_q;
        psum_wide = {1'b0, psum_q} + {9'd0, sample_precip};
        if (sample_valid) begin
            if (state_q == IDLE) begin
                tmax_n  = sample_temp;
                tmin_n  = sample_temp;
                psum_n  = {8'd0, sample_precip};
                wpeak_n = sample_wind;
            end else begin
                tmax_n  = (sample_temp > tmax_q) ? sample_temp : tmax_q;
                tmin_n  = (sample_temp < tmin_q) ? sample_temp : tmin_q;
                psum_n  = psum_wide[16] ? 16'hFFFF : psum_wide[15:0];
                wpeak_n = (sample_wind > wpeak_q) ? sample_wind : wpeak_q;
            end
            state_d = close ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 8'd0;
            tmax_q  <= 8'sd0;
            tmin_q  <= 8'sd0;
            psum_q  <= 16'd0;
            wpeak_q <= 8'd0;
        end else if (sample_valid) begin
            if (close) begin
                cnt_q   <= 8'd0;
                tmax_q  <= 8'sd0;
                tmin_q  <= 8'sd0;
                psum_q  <= 16'd0;
                wpeak_q <= 8'd0;
            end else begin
                cnt_q   <= cnt_q + 8'd1;
                tmax_q  <= tmax_n;
                tmin_q  <= tmin_n;
                psum_q  <= psum_n;
                wpeak_q <= wpeak_n;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat_valid         <= 1'b0;
            feat_temp_max      <= 4'd0;
            feat_temp_min      <= 4'd0;
            feat_precipitation <= 4'd0;
            feat_wind          <= 4'd0;
            overrun            <= 1'b0;
        end else begin
            if (load) begin
                feat_valid         <= 1'b1;
                feat_temp_max      <= quant_temp(tmax_n);
                feat_temp_min      <= quant_temp(tmin_n);
                feat_precipitation <= quant_u16(psum_n, PRECIP_SHIFT);
                feat_wind          <= quant_u16({8'd0, wpeak_n}, WIND_SHIFT);
            end else if (feat_valid && feat_ready) begin
                feat_valid <= 1'b0;
            end
            if (close && feat_valid && !feat_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_weather_feature_extractor.sv
// Directed bench for weather_feature_extractor with a 4-sample window and hand-computed feature codes.
module tb_weather_feature_extractor;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic signed [7:0] sample_temp;
    logic        [7:0] sample_precip;
    logic        [7:0] sample_wind;
    logic              feat_valid;
    logic              feat_ready;
    logic        [3:0] feat_temp_max;
    logic        [3:0] feat_temp_min;
    logic        [3:0] feat_precipitation;
    logic        [3:0] feat_wind;
    logic              overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    weather_feature_extractor #(.SAMPLES_PER_DAY(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .sample_valid       (sample_valid),
        .sample_temp        (sample_temp),
        .sample_precip      (sample_precip),
        .sample_wind        (sample_wind),
        .feat_valid         (feat_valid),
        .feat_ready         (feat_ready),
        .feat_temp_max      (feat_temp_max),
        .feat_temp_min      (feat_temp_min),
        .feat_precipitation (feat_precipitation),
        .feat_wind          (feat_wind),
        .overrun            (overrun)
    );

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample for exactly one edge; returns 1 time unit after that edge.
    task automatic send(input logic signed [7:0] t, input logic [7:0] p, input logic [7:0] w);
        sample_valid  = 1'b1;
        sample_temp   = t;
        sample_precip = p;
        sample_wind   = w;
        @(posedge clk);
        #1;
        sample_valid  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        sample_valid  = 1'b0;
        sample_temp   = 8'sd0;
        sample_precip = 8'd0;
        sample_wind   = 8'd0;
        feat_ready    = 1'b1;
        tick();
        tick();
        chk1("reset_valid",   feat_valid, 1'b0);
        chk1("reset_overrun", overrun,    1'b0);
        chk4("reset_tmax",    feat_temp_max, 4'd0);
        chk4("reset_precip",  feat_precipitation, 4'd0);
        rst = 1'b0;
        tick();

        // 1: basic window
        send(8'sd10, 8'd0, 8'd0);
        send(8'sd15, 8'd0, 8'd0);
        send(-8'sd5, 8'd0, 8'd0);
        chk1("t1_not_early", feat_valid, 1'b0);
        send(8'sd22, 8'd0, 8'd0);
        chk1("t1_valid", feat_valid, 1'b1);
        chk4("t1_tmax",  feat_temp_max, 4'd10);
        chk4("t1_tmin",  feat_temp_min, 4'd3);
        chk4("t1_precip", feat_precipitation, 4'd0);
        chk4("t1_wind",  feat_wind, 4'd0);
        tick();
        chk1("t1_taken", feat_valid, 1'b0);

        // 2: clamp at both ends
        repeat (4) send(-8'sd40, 8'd0, 8'd0);
        chk4("t2_lo_tmax", feat_temp_max, 4'd0);
        chk4("t2_lo_tmin", feat_temp_min, 4'd0);
        repeat (4) send(8'sd127, 8'd0, 8'd0);
        chk4("t2_hi_tmax", feat_temp_max, 4'd15);
        chk4("t2_hi_tmin", feat_temp_min, 4'd15);

        // 3: precipitation and wind quantisation
        repeat (4) send(8'sd0, 8'd200, 8'd0);
        chk4("t3_precip_sat", feat_precipitation, 4'd15);
        chk4("t3_tmax_zero",  feat_temp_max, 4'd5);
        send(8'sd0, 8'd8, 8'd5);
        send(8'sd0, 8'd8, 8'd90);
        send(8'sd0, 8'd8, 8'd20);
        send(8'sd0, 8'd8, 8'd0);
        chk4("t3_precip", feat_precipitation, 4'd4);
        chk4("t3_wind",   feat_wind, 4'd11);
        tick();

        // 4: consumer stalled across two windows
        feat_ready = 1'b0;
        repeat (4) send(8'sd0, 8'd0, 8'd16);
        chk1("t4_valid_a",   feat_valid, 1'b1);
        chk1("t4_no_ovr_a",  overrun, 1'b0);
        repeat (4) send(8'sd30, 8'd0, 8'd80);
        chk1("t4_valid_b",   feat_valid, 1'b1);
        chk4("t4_held_tmax", feat_temp_max, 4'd5);
        chk4("t4_held_wind", feat_wind, 4'd2);
        chk1("t4_overrun",   overrun, 1'b1);
        feat_ready = 1'b1;
        tick();
        chk1("t4_drop_valid", feat_valid, 1'b0);
        chk1("t4_ovr_sticky", overrun, 1'b1);

        // 5: window closes on the accepting edge
        pulse_rst();
        chk1("t5_ovr_cleared", overrun, 1'b0);
        feat_ready = 1'b0;
        repeat (4) send(8'sd10, 8'd0, 8'd0);
        chk4("t5_first_tmax", feat_temp_max, 4'd7);
        repeat (3) send(8'sd22, 8'd0, 8'd0);
        feat_ready = 1'b1;
        send(8'sd22, 8'd0, 8'd0);
        chk1("t5_valid_kept", feat_valid, 1'b1);
        chk4("t5_new_tmax",   feat_temp_max, 4'd10);
        chk1("t5_no_overrun", overrun, 1'b0);
        tick();
        chk1("t5_taken", feat_valid, 1'b0);

        // 6: reset mid-window discards partial data
        send(8'sd127, 8'd200, 8'd255);
        send(8'sd127, 8'd200, 8'd255);
        rst = 1'b1;
        #1;
        chk1("t6_async_rst_valid", feat_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        repeat (3) send(8'sd30, 8'd0, 8'd0);
        chk1("t6_not_early", feat_valid, 1'b0);
        send(8'sd30, 8'd0, 8'd0);
        chk1("t6_valid",  feat_valid, 1'b1);
        chk4("t6_tmax",   feat_temp_max, 4'd12);
        chk4("t6_tmin",   feat_temp_min, 4'd12);
        chk4("t6_precip", feat_precipitation, 4'd0);
        chk4("t6_wind",   feat_wind, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
